// File: rtl/dpwm_freq_pkg.sv
// Shared constants and the divisor clamp used by the DPWM carrier generator and duty comparator.
package dpwm_freq_pkg;

  localparam int unsigned DIV_W     = 7;
  localparam int unsigned MIN_DIV   = 2;
  localparam int unsigned RESET_DIV = 41;

  typedef logic [DIV_W-1:0] div_t;

  // Requests below the smallest legal divisor are raised to it.
  function automatic div_t clamp_div(input div_t req);
    return (req < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : req;
  endfunction

endpackage

// File: rtl/dpwm_freq_divider.sv
// DPWM carrier generator: 0..N-1 ramp, period-start strobe and divided clock.
// A new divisor is adopted only on a wrap, so a carrier period is never cut short.
module dpwm_freq_divider
  import dpwm_freq_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [DIV_W-1:0] paradiv,
  output logic [DIV_W-1:0] carrier,
  output logic             period_start,
  output logic             div_clk,
  output logic [DIV_W-1:0] div_active,
  output logic             upd_ack
);

  logic [DIV_W-1:0] carrier_q, carrier_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             pstart_q, pstart_d;
  logic             dclk_q, dclk_d;
  logic             ack_q, ack_d;
  logic [DIV_W-1:0] req_c;
  logic             tc_c;

  // Next-state logic; >= on terminal count lets an out-of-range ramp still wrap.
  always_comb begin
    req_c     = clamp_div(paradiv);
    tc_c      = (carrier_q >= (div_q - DIV_W'(1)));
    carrier_d = carrier_q;
    div_d     = div_q;
    dclk_d    = dclk_q;
    pstart_d  = 1'b0;
    ack_d     = 1'b0;
    if (en) begin
      if (tc_c) begin
        carrier_d = '0;
        div_d     = req_c;
      end else begin
        carrier_d = carrier_q + DIV_W'(1);
      end
      pstart_d = tc_c;
      ack_d    = tc_c && (req_c != div_q);
      dclk_d   = (carrier_d < (div_d >> 1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      carrier_q <= '0;
      div_q     <= DIV_W'(RESET_DIV);
      pstart_q  <= 1'b0;
      dclk_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      carrier_q <= carrier_d;
      div_q     <= div_d;
      pstart_q  <= pstart_d;
      dclk_q    <= dclk_d;
      ack_q     <= ack_d;
    end
  end

  assign carrier      = carrier_q;
  assign div_active   = div_q;
  assign period_start = pstart_q;
  assign div_clk      = dclk_q;
  assign upd_ack      = ack_q;

endmodule
